instr_mem_fetch_port: RTL and testbench
=======================================

// Module: instr_mem_fetch_port
// PURPOSE
//  Parametrised, handshaked successor to the combinational instruction store. Synchronous-read
//  instruction memory with request/response valid/ready channels, programmable wait states,
//  fault reporting and a word-write programming port for loading programs at runtime.
//  Sits between the PC/fetch stage and the IF/ID pipeline register.
// PARAMETERS
//  DATA_W       32   instruction width, bits
//  ADDR_W       32   byte-address width
//  DEPTH        128  words stored; power of two; IDX_W = $clog2(DEPTH)
//  WAIT_STATES  0    extra cycles between request accept and response (0..15)
//  FAULT_INSTR  0    value driven on RespInstr when RespFault=1 (MIPS NOP)
// PORTS
//  Clk        in   1       rising-edge clock
//  Reset      in   1       synchronous, active-high
//  ReqValid   in   1       fetch request present
//  ReqReady   out  1       block can accept request this cycle
//  ReqAddr    in   ADDR_W  byte address of instruction
//  RespValid  out  1       response held valid
//  RespReady  in   1       consumer accepts response
//  RespInstr  out  DATA_W  fetched word (FAULT_INSTR on fault)
//  RespFault  out  1       request was misaligned or out of range
//  ProgEn     in   1       write ProgData to word ProgAddr[IDX_W+1:2] this edge
//  ProgAddr   in   ADDR_W  byte address for programming write
//  ProgData   in   DATA_W  programming word
//  Busy       out  1       request in flight (state != IDLE)
// BEHAVIOUR
//  - Memory init at time zero: mem[i] = i*4. Reset does NOT clear memory.
//  - Reset: state=IDLE, ReqReady=0 during Reset cycle, RespValid=0, RespInstr=0, RespFault=0,
//    Busy=0, wait counter=0. Reset mid-transaction drops the in-flight request silently.
//  - ReqReady = (state==IDLE) & ~ProgEn & ~Reset. Accept = ReqValid & ReqReady; ReqAddr latched.
//  - FSM: IDLE -accept-> (WAIT_STATES==0 ? LOAD : WAIT); WAIT counts WAIT_STATES cycles, then
//    LOAD; LOAD reads mem[latched idx] into RespInstr, sets RespValid -> RESP;
//    RESP holds all response outputs stable until RespValid&RespReady, then IDLE.
//  - Latency accept-edge to RespValid high: 2 + WAIT_STATES cycles. Throughput: one request per
//    3 + WAIT_STATES cycles with RespReady tied high.
//  - Fault: latched addr[1:0]!=0 or addr >= DEPTH*4 -> RespFault=1, RespInstr=FAULT_INSTR;
//    fault response uses identical timing. Index uses addr[IDX_W+1:2] only after range check.
//  - ProgEn: write occurs on edge regardless of state (Reset excepted: no write while Reset=1).
//    Write landing in WAIT/LOAD cycle to the in-flight word IS visible in the response
//    (read sampled in LOAD, write-first on same edge). Write during RESP does not alter the
//    held RespInstr. ProgAddr out of range/misaligned: write ignored.
//  - ReqValid & ProgEn same cycle: programming wins; request not accepted (ReqReady=0).
//  - Request fields sampled only at accept; ReqAddr changes afterwards are ignored.
// STRUCTURE
//  - Shared package imem_pkg: state encoding localparams (S_IDLE, S_WAIT, S_LOAD, S_RESP),
//    MIPS_NOP constant, default DEPTH/DATA_W.
//  - One sub-module: imem_word_ram (single clock, 1 write port, 1 sync read port,
//    write-first on same-address collision, i*4 initial content). FSM/handshake in top.
// TESTING
//  1 Reset, WAIT_STATES=0, RespReady=1, fetch 0x0000_0010 -> RespValid 2 cycles after accept,
//    RespInstr=0x0000_0010, RespFault=0.
//  2 WAIT_STATES=3, fetch 0x0000_01FC -> RespValid 5 cycles after accept, RespInstr=0x0000_01FC;
//    ReqReady=0 and Busy=1 throughout.
//  3 Fetch 0x0000_0006 (misaligned) and 0x0000_0200 (range, DEPTH=128) -> RespFault=1,
//    RespInstr=0x0000_0000, same latency as good fetch.
//  4 ProgEn addr 0x0000_0020 data 0x2008_0005, then fetch 0x20 -> RespInstr=0x2008_0005;
//    ReqValid asserted with ProgEn same cycle -> ReqReady=0, request taken next cycle.
//  5 RespReady=0 for 4 cycles in RESP -> RespValid/RespInstr/RespFault stable, no new accept;
//    ProgEn to same word during RESP -> held RespInstr unchanged.
//  6 Reset asserted during WAIT -> next cycle RespValid=0, Busy=0; memory contents retained
//    (earlier programmed 0x2008_0005 still read back).

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants for the handshaked instruction memory fetch port.
package imem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_LOAD = 2'd2;
  localparam state_t S_RESP = 2'd3;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  localparam int DEF_DEPTH  = 128;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

  // Terminal value of the wait-state counter; zero when no wait states are configured
  function automatic logic [3:0] wait_last(input int ws);
    if (ws > 0) begin
      return 4'(ws - 1);
    end else begin
      return 4'd0;
    end
  endfunction

endpackage

// File: rtl/instr_mem_fetch_port_if.sv
// Fetch request/response channels plus the runtime programming port.
interface instr_mem_fetch_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ReqValid;
  logic              ReqReady;
  logic [ADDR_W-1:0] ReqAddr;
  logic              RespValid;
  logic              RespReady;
  logic [DATA_W-1:0] RespInstr;
  logic              RespFault;
  logic              ProgEn;
  logic [ADDR_W-1:0] ProgAddr;
  logic [DATA_W-1:0] ProgData;
  logic              Busy;

  // Fetch stage / loader side
  modport master (
    output ReqValid, ReqAddr, RespReady, ProgEn, ProgAddr, ProgData,
    input  ReqReady, RespValid, RespInstr, RespFault, Busy
  );

  // Memory side
  modport slave (
    input  ReqValid, ReqAddr, RespReady, ProgEn, ProgAddr, ProgData,
    output ReqReady, RespValid, RespInstr, RespFault, Busy
  );
endinterface

// File: rtl/imem_word_ram.sv
// Single-clock word RAM: one write port, one registered read port, write-first
// forwarding on a same-edge collision, power-up content word[i] = i*4.
module imem_word_ram
  import imem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] word_s [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    // Power-up value only; reset deliberately leaves stored words alone
    logic [DATA_W-1:0] word_q = DATA_W'(gi * 4);

    // Word storage: take a programming write addressed to this index, else hold
    always_ff @(posedge clk_i) begin
      if (we_i && (waddr_i == IDX_W'(gi))) begin
        word_q <= wdata_i;
      end else begin
        word_q <= word_q;
      end
    end

    assign word_s[gi] = word_q;
  end

  // Read register: loads only when enabled so a held response is immune to later writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= {DATA_W{1'b0}};
    end else if (re_i) begin
      if (we_i && (waddr_i == raddr_i)) begin
        rdata_q <= wdata_i;
      end else begin
        rdata_q <= word_s[raddr_i];
      end
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_fetch_port.sv
// Handshaked instruction fetch port: accepts one request at a time, optionally
// waits a fixed number of cycles, reads the word and holds the response until taken.
module instr_mem_fetch_port
  import imem_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DEPTH       = DEF_DEPTH,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] FAULT_INSTR = DATA_W'(MIPS_NOP)
) (
  input logic                   Clk,
  input logic                   Reset,
  instr_mem_fetch_port_if.slave bus
);

  localparam int                IDX_W      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);
  localparam logic [3:0]        WAIT_LAST  = wait_last(WAIT_STATES);

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fault_q, fault_d;

  logic              req_fault_s;
  logic              prog_fault_s;
  logic              req_ready_s;
  logic              accept_s;
  logic              ram_we_s;
  logic              ram_re_s;
  logic [DATA_W-1:0] ram_rdata_s;

  // Address legality and handshake qualifiers; programming always beats a fetch request
  always_comb begin
    req_fault_s  = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT);
    prog_fault_s = (bus.ProgAddr[1:0] != 2'b00) || (bus.ProgAddr >= ADDR_LIMIT);
    req_ready_s  = (state_q == S_IDLE) && !bus.ProgEn && !Reset;
    accept_s     = bus.ReqValid && req_ready_s;
    ram_we_s     = bus.ProgEn && !Reset && !prog_fault_s;
    ram_re_s     = (state_q == S_LOAD) && !req_fault_s;
  end

  // State register with the latched request, wait counter and response fault flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= {ADDR_W{1'b0}};
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic: IDLE -> [WAIT] -> LOAD -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          addr_d  = bus.ReqAddr;
          wcnt_d  = 4'd0;
          state_d = (WAIT_STATES == 0) ? S_LOAD : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          state_d = S_LOAD;
        end else begin
          wcnt_d  = wcnt_q + 4'd1;
        end
      end
      S_LOAD: begin
        fault_d = req_fault_s;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.RespReady) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: response fields come straight from registers, fault forces the filler word
  always_comb begin
    bus.ReqReady  = req_ready_s;
    bus.RespValid = (state_q == S_RESP);
    bus.Busy      = (state_q != S_IDLE);
    bus.RespFault = fault_q;
    if (fault_q) begin
      bus.RespInstr = FAULT_INSTR;
    end else begin
      bus.RespInstr = ram_rdata_s;
    end
  end

  imem_word_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .we_i    (ram_we_s),
    .waddr_i (bus.ProgAddr[IDX_W+1:2]),
    .wdata_i (bus.ProgData),
    .re_i    (ram_re_s),
    .raddr_i (addr_q[IDX_W+1:2]),
    .rdata_o (ram_rdata_s)
  );

endmodule

// File: tb/tb_instr_mem_fetch_port.sv
// Scoreboard bench for instr_mem_fetch_port: one instance without wait states,
// one with three; expected responses are queued at request acceptance.
module tb_instr_mem_fetch_port;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  localparam int WS [2] = '{0, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic [31:0] req_addr   [2];
  logic        resp_ready [2];
  logic        prog_en    [2];
  logic [31:0] prog_addr  [2];
  logic [31:0] prog_data  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_instr [2];
  logic        resp_fault [2];
  logic        busy       [2];

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb_q[$];
  logic [31:0] mdl [2][128];

  instr_mem_fetch_port_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  instr_mem_fetch_port_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  assign bus0.ReqValid  = req_valid[0];
  assign bus0.ReqAddr   = req_addr[0];
  assign bus0.RespReady = resp_ready[0];
  assign bus0.ProgEn    = prog_en[0];
  assign bus0.ProgAddr  = prog_addr[0];
  assign bus0.ProgData  = prog_data[0];
  assign bus1.ReqValid  = req_valid[1];
  assign bus1.ReqAddr   = req_addr[1];
  assign bus1.RespReady = resp_ready[1];
  assign bus1.ProgEn    = prog_en[1];
  assign bus1.ProgAddr  = prog_addr[1];
  assign bus1.ProgData  = prog_data[1];

  assign req_ready[0]  = bus0.ReqReady;
  assign resp_valid[0] = bus0.RespValid;
  assign resp_instr[0] = bus0.RespInstr;
  assign resp_fault[0] = bus0.RespFault;
  assign busy[0]       = bus0.Busy;
  assign req_ready[1]  = bus1.ReqReady;
  assign resp_valid[1] = bus1.RespValid;
  assign resp_instr[1] = bus1.RespInstr;
  assign resp_fault[1] = bus1.RespFault;
  assign busy[1]       = bus1.Busy;

  instr_mem_fetch_port #(.WAIT_STATES(0)) u_dut0 (.Clk(clk), .Reset(rst[0]), .bus(bus0));
  instr_mem_fetch_port #(.WAIT_STATES(3)) u_dut1 (.Clk(clk), .Reset(rst[1]), .bus(bus1));

  // Expected response for a fetch from the bench's own memory model
  function automatic exp_t exp_of(input int d, input logic [31:0] a);
    exp_t e;
    e.fault = (a[1:0] != 2'b00) || (a >= 32'd512);
    e.instr = e.fault ? 32'h0000_0000 : mdl[d][a[8:2]];
    return e;
  endfunction

  // One programming write; called at a falling edge, returns at the next one
  task automatic do_prog(input int d, input logic [31:0] a, input logic [31:0] data);
    prog_en[d] = 1'b1; prog_addr[d] = a; prog_data[d] = data;
    if ((a[1:0] == 2'b00) && (a < 32'd512)) mdl[d][a[8:2]] = data;
    @(negedge clk);
    prog_en[d] = 1'b0;
  endtask

  // Single fetch with latency, in-flight, stall and response checks
  task automatic do_fetch(input int d, input logic [31:0] a, input int stall,
                          input logic [31:0] hold_prog, input logic [31:0] fly_prog);
    exp_t e, got;
    int k;
    logic bad;
    logic [31:0] h_instr;
    logic h_fault;
    resp_ready[d] = (stall == 0);
    req_valid[d] = 1'b1; req_addr[d] = a;
    k = 0;
    #1;
    while (!req_ready[d] && k < 20) begin @(negedge clk); #1; k++; end
    n_tests++;
    if (req_ready[d] !== 1'b1) begin
      n_fail++; $display("FAIL accept_timeout d%0d addr %h: ReqReady %b want 1", d, a, req_ready[d]);
      req_valid[d] = 1'b0; resp_ready[d] = 1'b1; @(negedge clk); return;
    end
    e = exp_of(d, a);
    @(posedge clk); @(negedge clk);
    req_valid[d] = 1'b0; req_addr[d] = ~a;
    if (fly_prog != 32'h0000_0000) begin
      prog_en[d] = 1'b1; prog_addr[d] = a; prog_data[d] = fly_prog;
      mdl[d][a[8:2]] = fly_prog; e.instr = fly_prog;
    end
    sb_q.push_back(e);
    k = 1; bad = 1'b0;
    #1;
    while (!resp_valid[d] && k < 40) begin
      if (busy[d] !== 1'b1 || req_ready[d] !== 1'b0) bad = 1'b1;
      @(negedge clk); prog_en[d] = 1'b0; #1; k++;
    end
    n_tests++;
    if (k != 2 + WS[d]) begin
      n_fail++; $display("FAIL latency d%0d addr %h: got %0d cycles want %0d", d, a, k, 2 + WS[d]);
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL inflight_flags d%0d addr %h: Busy/ReqReady wrong, got bad=1 want 0", d, a);
    end
    h_instr = resp_instr[d]; h_fault = resp_fault[d]; bad = 1'b0;
    for (int s = 0; s < stall; s++) begin
      if (s == 0 && hold_prog != 32'h0000_0000) begin
        prog_en[d] = 1'b1; prog_addr[d] = a; prog_data[d] = hold_prog; mdl[d][a[8:2]] = hold_prog;
      end
      @(negedge clk); prog_en[d] = 1'b0; #1;
      if (resp_valid[d] !== 1'b1 || resp_instr[d] !== h_instr ||
          resp_fault[d] !== h_fault || req_ready[d] !== 1'b0) bad = 1'b1;
    end
    if (stall > 0) begin
      n_tests++;
      if (bad !== 1'b0) begin
        n_fail++; $display("FAIL resp_hold d%0d addr %h: response changed during stall, got bad=1 want 0", d, a);
      end
    end
    resp_ready[d] = 1'b1;
    #1;
    got.instr = resp_instr[d]; got.fault = resp_fault[d];
    e = sb_q.pop_front();
    n_tests++;
    if (got.instr !== e.instr) begin
      n_fail++; $display("FAIL resp_instr d%0d addr %h: got %h want %h", d, a, got.instr, e.instr);
    end
    n_tests++;
    if (got.fault !== e.fault) begin
      n_fail++; $display("FAIL resp_fault d%0d addr %h: got %b want %b", d, a, got.fault, e.fault);
    end
    @(negedge clk); #1;
    n_tests++;
    if (resp_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
      n_fail++; $display("FAIL return_idle d%0d addr %h: RespValid %b Busy %b want 0 0", d, a, resp_valid[d], busy[d]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({req_ready[d], resp_valid[d], resp_fault[d], busy[d]} !== 4'b0000 || resp_instr[d] !== 32'h0000_0000) begin
        n_fail++;
        $display("FAIL reset_state d%0d: rdy %b vld %b flt %b busy %b instr %h want all 0",
                 d, req_ready[d], resp_valid[d], resp_fault[d], busy[d], resp_instr[d]);
      end
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (req_ready[d] !== 1'b1) begin
        n_fail++; $display("FAIL ready_after_reset d%0d: got %b want 1", d, req_ready[d]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_fetch(0, 32'h0000_0010, 0, 32'h0, 32'h0);
    do_fetch(1, 32'h0000_01FC, 0, 32'h0, 32'h0);
  endtask

  task automatic test_fault();
    do_fetch(0, 32'h0000_0006, 0, 32'h0, 32'h0);
    do_fetch(0, 32'h0000_0200, 0, 32'h0, 32'h0);
    do_fetch(1, 32'h0000_0203, 0, 32'h0, 32'h0);
  endtask

  task automatic test_prog();
    prog_en[1] = 1'b1; prog_addr[1] = 32'h0000_0020; prog_data[1] = 32'h2008_0005;
    req_valid[1] = 1'b1; req_addr[1] = 32'h0000_0020;
    mdl[1][8] = 32'h2008_0005;
    #1;
    n_tests++;
    if (req_ready[1] !== 1'b0) begin
      n_fail++; $display("FAIL prog_blocks_req: ReqReady %b want 0", req_ready[1]);
    end
    @(negedge clk);
    prog_en[1] = 1'b0;
    do_fetch(1, 32'h0000_0020, 0, 32'h0, 32'h0);
    do_prog(1, 32'h0000_0022, 32'hBAD0_0002);
    do_prog(1, 32'h0000_0200, 32'hBAD0_0001);
    do_fetch(1, 32'h0000_0020, 0, 32'h0, 32'h0);
    do_fetch(1, 32'h0000_0000, 0, 32'h0, 32'h0);
  endtask

  task automatic test_inflight_prog();
    do_fetch(0, 32'h0000_0040, 0, 32'h0, 32'h1111_2222);
    do_fetch(1, 32'h0000_0044, 0, 32'h0, 32'h3333_4444);
    do_fetch(0, 32'h0000_0040, 0, 32'h0, 32'h0);
  endtask

  task automatic test_resp_stall();
    do_fetch(1, 32'h0000_0030, 4, 32'hDEAD_BEEF, 32'h0);
    do_fetch(1, 32'h0000_0030, 0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    exp_t e;
    int cyc, acc_n, last_acc, resp_n;
    addrs[0] = 32'h0000_0000; addrs[1] = 32'h0000_0004; addrs[2] = 32'h0000_01FC;
    cyc = 0; acc_n = 0; last_acc = -1; resp_n = 0;
    resp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = addrs[0];
    while (resp_n < 3 && cyc < 40) begin
      #1;
      if (resp_valid[0] === 1'b1) begin
        e = sb_q.pop_front();
        n_tests++;
        if (resp_instr[0] !== e.instr || resp_fault[0] !== e.fault) begin
          n_fail++; $display("FAIL b2b_resp #%0d: got %h/%b want %h/%b", resp_n, resp_instr[0], resp_fault[0], e.instr, e.fault);
        end
        resp_n++;
      end
      if (req_valid[0] && req_ready[0] === 1'b1) begin
        sb_q.push_back(exp_of(0, addrs[acc_n]));
        if (last_acc >= 0) begin
          n_tests++;
          if (cyc - last_acc != 3) begin
            n_fail++; $display("FAIL b2b_interval: got %0d cycles want 3", cyc - last_acc);
          end
        end
        last_acc = cyc; acc_n++;
      end
      @(posedge clk); @(negedge clk); cyc++;
      if (acc_n >= 3) req_valid[0] = 1'b0;
      else req_addr[0] = addrs[acc_n];
    end
    n_tests++;
    if (resp_n != 3) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d responses want 3", resp_n);
      sb_q.delete();
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    logic seen;
    resp_ready[1] = 1'b1; req_valid[1] = 1'b1; req_addr[1] = 32'h0000_0100;
    #1;
    n_tests++;
    if (req_ready[1] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_accept: ReqReady %b want 1", req_ready[1]);
    end
    @(negedge clk); req_valid[1] = 1'b0;
    @(negedge clk); rst[1] = 1'b1;
    #1;
    n_tests++;
    if (req_ready[1] !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ready: ReqReady %b want 0 during Reset", req_ready[1]);
    end
    @(negedge clk); #1;
    n_tests++;
    if (resp_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL midrst_drop: RespValid %b Busy %b want 0 0", resp_valid[1], busy[1]);
    end
    rst[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (resp_valid[1] !== 1'b0 || busy[1] !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ghost: dropped request produced activity, got 1 want 0");
    end
    @(negedge clk);
    do_fetch(1, 32'h0000_0020, 0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = 32'h0000_0000;
      resp_ready[d] = 1'b1; prog_en[d] = 1'b0;
      prog_addr[d] = 32'h0000_0000; prog_data[d] = 32'h0000_0000;
      for (int i = 0; i < 128; i++) mdl[d][i] = 32'(i * 4);
    end
    test_reset();
    test_basic();
    test_fault();
    test_prog();
    test_inflight_prog();
    test_resp_stall();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
